// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared CHIP-8 constants, timer type and saturating decrement helper
package chip8_pkg;

    localparam int CHIP8_TICK_HZ = 60;
    localparam int CHIP8_TIMER_W = 8;
    localparam int CHIP8_CLK_HZ  = 4857480;

    typedef logic [CHIP8_TIMER_W-1:0] timer_t;

    // Timers stop at zero instead of wrapping to 255.
    function automatic timer_t timer_dec(input timer_t v);
        return (v == '0) ? '0 : v - timer_t'(1);
    endfunction

endpackage

// File: rtl/chip8_tone_div.sv
// rtl/chip8_tone_div.sv - half-period divider producing the square-wave tone phase
module chip8_tone_div #(
    parameter int HALF = 5519
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic phase
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    // Disabled means parked at zero, so each enable starts on a low half-period.
    always_comb begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (en) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/chip8_timer_audio.sv
// rtl/chip8_timer_audio.sv - CHIP-8 delay/sound timers with 60 Hz tick and gated speaker tone
module chip8_timer_audio
    import chip8_pkg::*;
#(
    parameter int CLK_HZ    = CHIP8_CLK_HZ,
    parameter int TONE_HZ   = 440,
    parameter int MIN_BEEP  = 2,
    parameter int USE_VSYNC = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vsync,
    input  logic                     dt_we,
    input  logic                     st_we,
    input  logic [CHIP8_TIMER_W-1:0] wdata,
    input  logic                     mute,
    output logic [CHIP8_TIMER_W-1:0] dt_value,
    output logic [CHIP8_TIMER_W-1:0] st_value,
    output logic                     tick,
    output logic                     beep,
    output logic                     spkr
);

    localparam int     HALF       = CLK_HZ / (2 * TONE_HZ);
    localparam timer_t MIN_BEEP_V = timer_t'(MIN_BEEP);

    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    // Assert immediately, release two clocks later so no flop sees a runt deassert.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    logic tick_d, tick_q;

    generate
        if (USE_VSYNC != 0) begin : g_vsync
            // [0] metastable stage, [1] synchronised vsync, [2] previous synchronised value
            logic [2:0] vs_q, vs_d;

            always_comb vs_d = {vs_q[1:0], vsync};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) vs_q <= '0;
                else        vs_q <= vs_d;
            end

            assign tick_d = vs_q[1] & ~vs_q[2];
        end else begin : g_div
            localparam int DIV = CLK_HZ / CHIP8_TICK_HZ;
            localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
            localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

            logic [DW-1:0] div_q, div_d;
            logic          unused_vsync;

            assign unused_vsync = vsync;

            always_comb div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) div_q <= '0;
                else        div_q <= div_d;
            end

            assign tick_d = (div_q == DIV_LAST);
        end
    endgenerate

    timer_t dt_q, dt_d;
    timer_t st_q, st_d;
    logic   beep_q, beep_d;
    logic   spkr_q, spkr_d;
    logic   phase;

    // A write in the same cycle as a tick overrides the decrement.
    always_comb begin
        dt_d = dt_q;
        st_d = st_q;
        if (tick_q) begin
            dt_d = timer_dec(dt_q);
            st_d = timer_dec(st_q);
        end
        if (dt_we) dt_d = wdata;
        if (st_we) st_d = wdata;
        beep_d = (st_q >= MIN_BEEP_V);
        spkr_d = beep_q & phase & ~mute;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
            dt_q   <= '0;
            st_q   <= '0;
            beep_q <= 1'b0;
            spkr_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
            dt_q   <= dt_d;
            st_q   <= st_d;
            beep_q <= beep_d;
            spkr_q <= spkr_d;
        end
    end

    chip8_tone_div #(
        .HALF (HALF)
    ) u_tone (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (beep_q),
        .phase (phase)
    );

    assign dt_value = dt_q;
    assign st_value = st_q;
    assign tick     = tick_q;
    assign beep     = beep_q;
    assign spkr     = spkr_q;

endmodule
